// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the lab datapath cells.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    localparam int unsigned DATA_W = 8;

endpackage

// File: rtl/full_subtractor1.sv
// 1-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor1 (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor (a - b), LSB first, with start/done handshake
// and held result flags.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned N = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow,
    output logic         overflow,
    output logic         zero
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    sub_state_t    state_q;
    logic [N-1:0]  sa_q, sb_q, res_q;
    logic          bw_q;
    logic [CW-1:0] cnt_q;
    logic          amsb_q, bmsb_q;
    logic          ready_q, done_q, borrow_q, ovf_q, zero_q;
    logic [N-1:0]  diff_q;
    logic          bit_d, bw_d;

    full_subtractor1 u_fs (
        .x   (sa_q[0]),
        .y   (sb_q[0]),
        .bin (bw_q),
        .d   (bit_d),
        .bout(bw_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            bw_q     <= 1'b0;
            cnt_q    <= '0;
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        bw_q    <= 1'b0;
                        cnt_q   <= '0;
                        amsb_q  <= a[N-1];
                        bmsb_q  <= b[N-1];
                        ready_q <= 1'b0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Result fills from the MSB so it is LSB-aligned after N shifts.
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    res_q <= {bit_d, res_q[N-1:1]};
                    bw_q  <= bw_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q   <= 1'b1;
                    diff_q   <= res_q;
                    borrow_q <= bw_q;
                    ovf_q    <= (amsb_q != bmsb_q) && (res_q[N-1] != amsb_q);
                    zero_q   <= (res_q == '0);
                    ready_q  <= 1'b1;
                    state_q  <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor; computes diff = a - b, LSB first, one bit per clock.
- Uses a single 1-bit full-subtractor cell, the inverse arithmetic direction of the existing 1-bit full-adder cell.
- Start/done handshake; result and flags held until the next accepted operation.
- Intended as the area-minimal arithmetic unit for the lab datapath, paired with the adder cells.

Parameters:
- N, 8, operand/result width in bits (N >= 2)
- CW, $clog2(N+1), bit-counter width (derived, not overridden)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- a  input  N  minuend, sampled on the accepting edge
- b  input  N  subtrahend, sampled on the accepting edge
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse when the result becomes valid
- diff  output  N  a - b modulo 2^N
- borrow  output  1  unsigned borrow out (a < b)
- overflow  output  1  signed two's-complement overflow
- zero  output  1  diff == 0

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high; all state changes on the rising clk edge.
- Reset: state=IDLE, ready=1, done=0, diff=0, borrow=0, overflow=0, zero=0, counter=0, internal borrow=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on start=1:
  - load sa<=a, sb<=b, bw<=0, cnt<=0
  - latch a[N-1], b[N-1] for overflow
  - ready drops next cycle.
- SHIFT, each cycle:
  - d = sa[0]^sb[0]^bw; bo = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&bw)
  - sa, sb shift right; d shifts into result MSB; bw<=bo; cnt<=cnt+1
  - when cnt==N-1 (Nth bit), go to DONE.
- DONE (1 cycle): done=1; outputs update in this cycle; next state IDLE.
- Output update in DONE:
  - diff = assembled result; borrow = final bw
  - overflow = (a_msb != b_msb) && (diff[N-1] != a_msb); zero = (diff == 0).
- Latency: start accepted at edge k -> done high during the cycle after edge k+N+1; next start can be accepted at edge k+N+2.
- diff/borrow/overflow/zero hold stable from DONE until the next DONE or reset; they do not change during a new SHIFT.
- start while ready=0 is ignored, with no queuing.
- start held high continuously gives back-to-back operations; each is accepted in IDLE.
- a/b changes after acceptance have no effect.
- rst asserted mid-SHIFT or in DONE aborts the operation: outputs return to reset values, no done pulse, IDLE on the next cycle.
- rst has priority over start on the same edge.
- Wrap-around: result is modulo 2^N (0 - 1 = all ones, borrow=1).

Decomposition:
- Shared package arith_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t
  - default width constant DATA_W = 8.
- Sub-module full_subtractor1:
  - inputs x, y, bin; outputs d, bout
  - combinational; mirrors fullAdder1's port style; instantiated once.

Test Plan:
- Reset: after rst held 2 cycles -> ready=1, done=0, diff=0x00, all flags 0.
- Basic (N=8): a=0x05, b=0x03 -> diff=0x02, borrow=0, overflow=0, zero=0.
- Borrow and latency: a=0x03, b=0x05 -> diff=0xFE, borrow=1, overflow=0; done high exactly on the 10th cycle after the start edge.
- Overflow: a=0x80, b=0x01 -> diff=0x7F, overflow=1, borrow=0.
- Zero: a=0x3C, b=0x3C -> diff=0x00, zero=1, borrow=0.
- Start ignored while busy:
  - run a=0xFF, b=0x01; pulse start with a=0x00, b=0x01 at cycle 4
  - -> one done only, diff=0xFE.
- Reset mid-op: assert rst at cycle 5 of an operation -> no done pulse, outputs 0, ready=1.
- Exhaustive: N=4 random/exhaustive sweep vs a reference model.
